// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR SDRAM x4 responder: command codes,
// mode-register layout, burst states and the mode-register decoder.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_RD_BURST
    } burst_state_e;

    // Mode-register field offsets within addr
    localparam int MR_BL_LSB = 0;
    localparam int MR_BT_BIT = 3;
    localparam int MR_CL_LSB = 4;

    typedef struct packed {
        logic [1:0] bl_code;    // burst length = 2**bl_code
        logic       interleave;
        logic       cl3;        // 1: CAS latency 3, 0: CAS latency 2
    } mode_t;

    typedef struct packed {
        logic  ok;
        mode_t mode;
    } mode_dec_t;

    localparam mode_t MODE_RESET = '{bl_code: 2'd0, interleave: 1'b0, cl3: 1'b0};

    // Decode a LOAD MODE opcode; ok=0 for reserved burst lengths or CAS latencies
    function automatic mode_dec_t mode_decode(input logic [6:0] op);
        mode_dec_t r;
        r.ok              = (op[MR_BL_LSB+2] == 1'b0) &&
                            ((op[MR_CL_LSB+:3] == 3'd2) || (op[MR_CL_LSB+:3] == 3'd3));
        r.mode.bl_code    = op[MR_BL_LSB+:2];
        r.mode.interleave = op[MR_BT_BIT];
        r.mode.cl3        = op[MR_CL_LSB];
        return r;
    endfunction

    // Low-column mask covering the bits that wrap inside a burst
    function automatic logic [2:0] bl_mask(input logic [1:0] bl_code);
        case (bl_code)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// CAS-latency read pipeline: carries beat-valid and data from the
// synchronous array read to the DQ pins, with a separate two-deep DQM
// delay line. Everything holds while cke is low.
module sdram_rd_pipe #(
    parameter int DQ_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cke,
    input  logic            cl3,
    input  logic            issue,
    input  logic            dqm,
    input  logic [DQ_W-1:0] rd_data,
    output logic [DQ_W-1:0] dq_o,
    output logic            dq_oe
);

    logic            v0, v1, v2;
    logic            m1, m2;
    logic [DQ_W-1:0] d1, d2;
    logic            drive;

    // Stage 0 is the array output register; CL2 taps stage 1, CL3 taps stage 2
    always_comb begin
        drive = (cl3 ? v2 : v1) & ~m2;
    end

    // Shift valid/data/mask one stage per enabled clock
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0    <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            m1    <= 1'b0;
            m2    <= 1'b0;
            d1    <= '0;
            d2    <= '0;
            dq_o  <= '0;
            dq_oe <= 1'b0;
        end else if (cke) begin
            v0    <= issue;
            m1    <= dqm & issue;
            m2    <= m1;
            v1    <= v0;
            d1    <= rd_data;
            v2    <= v1;
            d2    <= d1;
            dq_oe <= drive;
            dq_o  <= drive ? (cl3 ? d2 : d1) : '0;
        end
    end

endmodule

// File: rtl/sdram_x4_responder.sv
// SDR SDRAM x4 device responder: command decode, mode register,
// per-bank open-row tracking, burst sequencing and a small array.
//
//   state        | meaning
//   ST_IDLE      | no burst in progress
//   ST_WR_BURST  | write beats being stored, one per enabled clock
//   ST_RD_BURST  | read beats being issued into the CAS pipeline
import sdram_pkg::*;

module sdram_x4_responder #(
    parameter int DQ_W   = 4,
    parameter int ROW_W  = 12,
    parameter int COL_W  = 10,
    parameter int MEM_AW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cke,
    input  logic             cs_n,
    input  logic             ras_n,
    input  logic             cas_n,
    input  logic             we_n,
    input  logic [ROW_W-1:0] addr,
    input  logic [1:0]       ba,
    input  logic             dqm,
    input  logic [DQ_W-1:0]  dq_i,
    output logic [DQ_W-1:0]  dq_o,
    output logic             dq_oe,
    output logic [3:0]       bank_open,
    output logic             err
);

    localparam int CW = MEM_AW - 2;   // column bits that reach the array

    burst_state_e     state_q;
    logic [1:0]       bank_q;
    logic [CW-1:0]    col_q;
    logic [2:0]       cnt_q;
    logic             ap_q;
    mode_t            mode_q;
    logic [3:0]       open_q;
    logic             err_q;
    logic [ROW_W-1:0] row_q [4];

    logic [DQ_W-1:0]  mem [2**MEM_AW];
    logic [DQ_W-1:0]  rd_data;

    cmd_e             cmd;
    mode_dec_t        dec;
    logic [COL_W-1:0] col_full;
    logic             rw_ok, pre_hit, cont, issue, b_wr, b_ap, last;
    logic [1:0]       b_bank;
    logic [CW-1:0]    b_col;
    logic [2:0]       b_cnt, mask, low;
    logic [MEM_AW-1:0] b_addr;
    logic             unused_bits;

    assign col_full  = addr[COL_W-1:0];
    assign dec       = mode_decode(addr[6:0]);
    assign bank_open = open_q;
    assign err       = err_q;
    // Row is tracked for protocol fidelity only; storage ignores it
    assign unused_bits = ^{row_q[0], row_q[1], row_q[2], row_q[3], col_full[COL_W-1:CW]};

    // Command decode and selection of the beat issued this clock
    always_comb begin
        cmd     = (cke && !cs_n) ? cmd_e'({ras_n, cas_n, we_n}) : CMD_NOP;
        rw_ok   = ((cmd == CMD_RD) || (cmd == CMD_WR)) && open_q[ba];
        pre_hit = (cmd == CMD_PRE) && (addr[10] || (ba == bank_q));
        cont    = cke && (state_q != ST_IDLE) && !rw_ok && (cmd != CMD_BST) && !pre_hit;
        issue   = rst_n && (rw_ok || cont);
        b_bank  = bank_q;
        b_col   = col_q;
        b_cnt   = cnt_q;
        b_wr    = (state_q == ST_WR_BURST);
        b_ap    = ap_q;
        if (rw_ok) begin
            b_bank = ba;
            b_col  = col_full[CW-1:0];
            b_cnt  = 3'd0;
            b_wr   = (cmd == CMD_WR);
            b_ap   = addr[10];
        end
        mask   = bl_mask(mode_q.bl_code);
        low    = mode_q.interleave ? (b_col[2:0] ^ b_cnt) : (b_col[2:0] + b_cnt);
        b_addr = {b_bank, b_col[CW-1:3], (b_col[2:0] & ~mask) | (low & mask)};
        last   = issue && (b_cnt == mask);
    end

    // Single-port array: at most one beat (read or write) per clock
    always_ff @(posedge clk) begin
        if (issue && b_wr && !dqm) begin
            mem[b_addr] <= dq_i;
        end
        if (issue && !b_wr) begin
            rd_data <= mem[b_addr];
        end
    end

    // Burst FSM, bank state, mode register and error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bank_q  <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            ap_q    <= 1'b0;
            mode_q  <= MODE_RESET;
            open_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;

            if (issue) begin
                state_q <= last ? ST_IDLE : (b_wr ? ST_WR_BURST : ST_RD_BURST);
                bank_q  <= b_bank;
                col_q   <= b_col;
                cnt_q   <= b_cnt + 3'd1;
                ap_q    <= b_ap;
            end else if ((cmd == CMD_BST) || pre_hit) begin
                state_q <= ST_IDLE;
            end

            case (cmd)
                CMD_ACT: begin
                    if (open_q[ba]) begin
                        err_q <= 1'b1;
                    end else begin
                        open_q[ba] <= 1'b1;
                        row_q[ba]  <= addr;
                    end
                end
                CMD_PRE: begin
                    if (addr[10]) open_q <= '0;
                    else          open_q[ba] <= 1'b0;
                end
                CMD_REF: begin
                    if (|open_q) err_q <= 1'b1;
                end
                CMD_LMR: begin
                    if ((|open_q) || (state_q != ST_IDLE) || !dec.ok) err_q <= 1'b1;
                    else mode_q <= dec.mode;
                end
                CMD_RD, CMD_WR: begin
                    if (!open_q[ba]) err_q <= 1'b1;
                end
                default: ;
            endcase

            // Auto-precharge closes the bank once its final beat has issued
            if (last && b_ap) begin
                open_q[b_bank] <= 1'b0;
            end
        end
    end

    sdram_rd_pipe #(.DQ_W(DQ_W)) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .cke     (cke),
        .cl3     (mode_q.cl3),
        .issue   (issue && !b_wr),
        .dqm     (dqm),
        .rd_data (rd_data),
        .dq_o    (dq_o),
        .dq_oe   (dq_oe)
    );

endmodule
